// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and sizing helpers for the FIFO read-side arbiter.
package fifo_rd_arb_pkg;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        OUT     = 2'd3
    } arb_state_t;

    localparam int unsigned MAX_FIFOS = 16;
    localparam int unsigned MAX_IDX_W = $clog2(MAX_FIFOS);

    // Index width for n FIFOs; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n < 2) return 1;
        return ($clog2(n) > MAX_IDX_W) ? MAX_IDX_W : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: the first request after 'last' wins.
module rr_arbiter
    import fifo_rd_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
)(
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last) + k) % N;
            if (!found && req[idx[IW-1:0]]) begin
                gnt[idx[IW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin read arbiter draining several FIFO read ports into one valid/ready stream.
// Optional multi-word bursts per grant are enabled by defining FIFO_RD_ARB_BURST_EN.
module fifo_rd_arbiter
    import fifo_rd_arb_pkg::*;
#(
    parameter int unsigned NUM_FIFOS  = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
)(
    input  logic                            rdclk,
    input  logic                            rdrst,
    input  logic [NUM_FIFOS-1:0]            fifo_empty,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_FIFOS-1:0]            rd_en,
    output logic [NUM_FIFOS-1:0]            grant,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_FIFOS)-1:0]    out_src
);

    localparam int unsigned IDX_W = idx_width(NUM_FIFOS);

    if (NUM_FIFOS < 2 || NUM_FIFOS > MAX_FIFOS || BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_cfg
        $error("fifo_rd_arbiter: NUM_FIFOS or BURST_LEN out of range");
    end

    arb_state_t           state, state_nxt;
    logic [IDX_W-1:0]     last, pick_idx;
    logic [NUM_FIFOS-1:0] pick;
    logic                 xfer, more;

    rr_arbiter #(.N(NUM_FIFOS), .IW(IDX_W)) u_rr (
        .req  (~fifo_empty),
        .last (last),
        .gnt  (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++)
            if (pick[i]) pick_idx = IDX_W'(i);
    end

    assign xfer = out_valid & out_ready;

`ifdef FIFO_RD_ARB_BURST_EN
    logic [7:0] burst_cnt;

    always_ff @(posedge rdclk or posedge rdrst) begin
        if (rdrst)                            burst_cnt <= 8'd1;
        else if (state == ARB && |pick)       burst_cnt <= 8'd1;
        else if (state == OUT && xfer && more) burst_cnt <= burst_cnt + 8'd1;
    end

    // Empty flag here already reflects the read just captured.
    assign more = (32'(burst_cnt) < BURST_LEN) && !fifo_empty[last];
`else
    assign more = 1'b0;
`endif

    always_ff @(posedge rdclk or posedge rdrst) begin
        if (rdrst) state <= ARB;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = '0;
        unique case (state)
            ARB:     if (|pick) state_nxt = READ;
            READ: begin
                rd_en     = grant & ~fifo_empty;
                state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = OUT;
            OUT:     if (xfer) state_nxt = more ? READ : ARB;
            default: state_nxt = ARB;
        endcase
    end

    // 'last' doubles as the index of the current grant.
    always_ff @(posedge rdclk or posedge rdrst) begin
        if (rdrst) begin
            grant     <= '0;
            last      <= IDX_W'(NUM_FIFOS - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            case (state)
                ARB: if (|pick) begin
                    grant <= pick;
                    last  <= pick_idx;
                end
                CAPTURE: begin
                    out_data  <= rd_data[last*DATA_WIDTH +: DATA_WIDTH];
                    out_src   <= last;
                    out_valid <= 1'b1;
                end
                OUT: if (xfer) begin
                    out_valid <= 1'b0;
                    if (!more) grant <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Randomised self-checking bench for fifo_rd_arbiter against a transaction-level round-robin model.
module tb_fifo_rd_arbiter;

    localparam int unsigned NF = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned BL = 4;
`ifdef FIFO_RD_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          rdclk = 1'b0;
    logic          rdrst;
    logic [NF-1:0] fifo_empty, rd_en, grant;
    logic [NF*DW-1:0] rd_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;

    int tests = 0;
    int fails = 0;
    int mon_bad = 0;
    int model_last;

    logic [DW-1:0] src_q [NF][$];
    int            rd_ptr [NF] = '{default: 0};
    logic [DW-1:0] mq [NF][$];
    int            exp_src [$];
    logic [DW-1:0] exp_dat [$];

    always #5 rdclk = ~rdclk;

    fifo_rd_arbiter #(.NUM_FIFOS(NF), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .rdclk      (rdclk),
        .rdrst      (rdrst),
        .fifo_empty (fifo_empty),
        .rd_data    (rd_data),
        .rd_en      (rd_en),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src)
    );

    // FIFO read sides: data one cycle after rd_en, registered empty flags.
    always @(posedge rdclk) begin
        for (int i = 0; i < NF; i++) begin
            if (rd_en[i] && rd_ptr[i] < src_q[i].size()) begin
                rd_data[i*DW +: DW] <= src_q[i][rd_ptr[i]];
                rd_ptr[i]           <= rd_ptr[i] + 1;
                fifo_empty[i]       <= (rd_ptr[i] + 1 >= src_q[i].size());
            end else begin
                fifo_empty[i] <= (rd_ptr[i] >= src_q[i].size());
            end
        end
    end

    always @(negedge rdclk)
        if (rdrst === 1'b0 && (!$onehot0(rd_en) || (rd_en & fifo_empty) != '0))
            mon_bad++;

    task automatic push(input int f, input int n);
        for (int k = 0; k < n; k++) src_q[f].push_back(DW'($urandom));
    endtask

    // Expected transfer order: round-robin from last+1, BL words per grant when bursting.
    task automatic build_expected();
        int sel, n;
        for (int f = 0; f < NF; f++) begin
            mq[f].delete();
            for (int k = rd_ptr[f]; k < src_q[f].size(); k++) mq[f].push_back(src_q[f][k]);
        end
        exp_src.delete();
        exp_dat.delete();
        forever begin
            sel = -1;
            for (int k = 1; k <= NF; k++)
                if (sel < 0 && mq[(model_last + k) % NF].size() > 0) sel = (model_last + k) % NF;
            if (sel < 0) break;
            model_last = sel;
            n = 0;
            do begin
                exp_src.push_back(sel);
                exp_dat.push_back(mq[sel].pop_front());
                n++;
            end while (BURST && n < BL && mq[sel].size() > 0);
        end
    endtask

    task automatic run_check(input string name, input bit rnd);
        int got = 0;
        int n, budget;
        build_expected();
        n = exp_src.size();
        budget = 30 * n + 40;
        while (got < n && budget > 0) begin
            @(negedge rdclk);
            budget--;
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (out_valid && out_ready) begin
                tests++;
                if (out_src !== 2'(exp_src[got]) || out_data !== exp_dat[got]) begin
                    fails++;
                    $display("FAIL %s[%0d] got src=%0d data=%h, required src=%0d data=%h",
                             name, got, out_src, out_data, exp_src[got], exp_dat[got]);
                end
                got++;
            end
        end
        tests++;
        if (got != n) begin
            fails++;
            $display("FAIL %s_count got %0d transfers, required %0d", name, got, n);
        end
        out_ready = 1'b1;
        repeat (8) @(negedge rdclk);
        tests++;
        if (out_valid !== 1'b0 || grant !== '0 || rd_en !== '0) begin
            fails++;
            $display("FAIL %s_idle got valid=%b grant=%b rd_en=%b, required all 0",
                     name, out_valid, grant, rd_en);
        end
    endtask

    task automatic test_reset();
        rdrst = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(negedge rdclk);
        tests++;
        if (rd_en !== '0 || grant !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
            fails++;
            $display("FAIL reset_values got rd_en=%b grant=%b valid=%b data=%h src=%0d, required 0",
                     rd_en, grant, out_valid, out_data, out_src);
        end
        rdrst = 1'b0;
        model_last = NF - 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge rdclk);
            tests++;
            if (rd_en !== '0 || grant !== '0 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL empty_idle cycle %0d got rd_en=%b grant=%b valid=%b, required 0",
                         c, rd_en, grant, out_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        for (int f = 0; f < NF; f++) push(f, 2);
        run_check("round_robin", 1'b0);
    endtask

    task automatic test_single_read();
        logic [DW-1:0] w;
        int budget = 20;
        out_ready = 1'b1;
        @(negedge rdclk);
        push(2, 1);
        w = src_q[2][src_q[2].size() - 1];
        while (fifo_empty[2] !== 1'b0 && budget > 0) begin
            @(negedge rdclk);
            budget--;
        end
        @(negedge rdclk);
        tests++;
        if (rd_en !== 4'b0100) begin
            fails++;
            $display("FAIL single_rd_en got %b, required 0100", rd_en);
        end
        @(negedge rdclk);
        tests++;
        if (rd_en !== '0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_capture got rd_en=%b valid=%b, required 0000 and 0", rd_en, out_valid);
        end
        @(negedge rdclk);
        tests++;
        if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== w) begin
            fails++;
            $display("FAIL single_out got valid=%b src=%0d data=%h, required 1, 2, %h",
                     out_valid, out_src, out_data, w);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge rdclk);
            tests++;
            if (rd_en !== '0 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL single_no_reread cycle %0d got rd_en=%b valid=%b, required 0", c, rd_en, out_valid);
            end
        end
        model_last = 2;
    endtask

    task automatic test_burst();
        @(negedge rdclk);
        rdrst = 1'b1;
        @(negedge rdclk);
        rdrst = 1'b0;
        model_last = NF - 1;
        push(1, 6);
        push(3, 2);
        run_check("burst", 1'b0);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w;
        int budget = 20;
        int xfers = 0;
        out_ready = 1'b0;
        @(negedge rdclk);
        push(0, 1);
        w = src_q[0][src_q[0].size() - 1];
        while (out_valid !== 1'b1 && budget > 0) begin
            @(negedge rdclk);
            budget--;
        end
        for (int c = 0; c < 10; c++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== w || out_src !== 2'd0 || rd_en !== '0) begin
                fails++;
                $display("FAIL hold cycle %0d got valid=%b data=%h src=%0d rd_en=%b, required 1 %h 0 0000",
                         c, out_valid, out_data, out_src, rd_en, w);
            end
            @(negedge rdclk);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (out_valid && out_ready) xfers++;
            @(negedge rdclk);
        end
        tests++;
        if (xfers != 1) begin
            fails++;
            $display("FAIL hold_release got %0d transfers, required 1", xfers);
        end
        model_last = 0;
    endtask

    task automatic test_reset_mid_read();
        int budget = 30;
        out_ready = 1'b1;
        @(negedge rdclk);
        push(2, 3);
        while (rd_en === '0 && budget > 0) begin
            @(negedge rdclk);
            budget--;
        end
        tests++;
        if (rd_en !== 4'b0100) begin
            fails++;
            $display("FAIL midrst_setup got rd_en=%b, required 0100", rd_en);
        end
        rdrst = 1'b1;
        #1;
        tests++;
        if (rd_en !== '0 || grant !== '0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_async got rd_en=%b grant=%b valid=%b, required 0", rd_en, grant, out_valid);
        end
        @(negedge rdclk);
        push(0, 1);
        @(negedge rdclk);
        rdrst = 1'b0;
        model_last = NF - 1;
        budget = 20;
        while (grant === '0 && budget > 0) begin
            @(negedge rdclk);
            budget--;
        end
        tests++;
        if (grant !== 4'b0001) begin
            fails++;
            $display("FAIL midrst_first_grant got %b, required 0001", grant);
        end
        run_check("post_reset", 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            @(negedge rdclk);
            for (int f = 0; f < NF; f++) push(f, $urandom_range(0, 3));
            run_check("random", 1'b1);
        end
    endtask

    task automatic test_protocol();
        tests++;
        if (mon_bad != 0) begin
            fails++;
            $display("FAIL rd_en_legal got %0d bad cycles, required 0", mon_bad);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_burst();
        test_backpressure();
        test_reset_mid_read();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish, required completion");
        $fatal(1);
    end

endmodule
